// File: rtl/edge_shift_register_pkg.sv
`default_nettype none
// ============================================================================
// edge_shift_register_pkg : shared sizing helper and shift-direction encodings
// Revision: 1.0
// ============================================================================
package edge_shift_register_pkg;

  localparam bit SHIFT_LEFT  = 1'b1;
  localparam bit SHIFT_RIGHT = 1'b0;

  // Bit-count width must hold 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_shift_register_if.sv
`default_nettype none
// ============================================================================
// edge_shift_register_if : strobe/data bundle between conditioner and shifter
// Revision: 1.0
// ============================================================================
interface edge_shift_register_if #(
  parameter int WIDTH = 8
);
  import edge_shift_register_pkg::*;

  localparam int CW = int'(cnt_width(WIDTH));

  logic             peripheralclkedge;
  logic             serialdatain;
  logic             parallelload;
  logic [WIDTH-1:0] paralleldatain;
  logic [WIDTH-1:0] paralleldataout;
  logic             serialdataout;
  logic [CW-1:0]    bitcount;
  logic             framedone;

  modport master (
    output peripheralclkedge, serialdatain, parallelload, paralleldatain,
    input  paralleldataout, serialdataout, bitcount, framedone
  );

  modport slave (
    input  peripheralclkedge, serialdatain, parallelload, paralleldatain,
    output paralleldataout, serialdataout, bitcount, framedone
  );

endinterface
`default_nettype wire

// File: rtl/edge_shift_register_frame_bit_counter.sv
`default_nettype none
// ============================================================================
// frame_bit_counter : mod-MODULUS counter with clear, increment, wrap pulse
// Revision: 1.0
// ============================================================================
module frame_bit_counter #(
  parameter int MODULUS = 8,
  parameter int CW      = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clr_i,
  input  wire logic          inc_i,
  output logic [CW-1:0]      count_o,
  output logic               wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  // Clear beats increment; wrap is registered so it lands the cycle after the last increment.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule
`default_nettype wire

// File: rtl/edge_shift_register.sv
`default_nettype none
// ============================================================================
// edge_shift_register : SIPO/PISO shifter driven by the conditioner's strobes
// Revision: 1.0
// ============================================================================
module edge_shift_register
  import edge_shift_register_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  edge_shift_register_if.slave   bus
);

  localparam int CW = int'(cnt_width(WIDTH));

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST == SHIFT_LEFT) begin : g_shift_left
      assign w_shifted         = {shreg_q[WIDTH-2:0], bus.serialdatain};
      assign bus.serialdataout = shreg_q[WIDTH-1];
    end else begin : g_shift_right
      assign w_shifted         = {bus.serialdatain, shreg_q[WIDTH-1:1]};
      assign bus.serialdataout = shreg_q[0];
    end
  endgenerate

  // A shift strobe coincident with a load is dropped.
  always_comb begin
    shreg_d = shreg_q;
    if (bus.parallelload) begin
      shreg_d = bus.paralleldatain;
    end else if (bus.peripheralclkedge) begin
      shreg_d = w_shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign bus.paralleldataout = shreg_q;

  frame_bit_counter #(
    .MODULUS (WIDTH),
    .CW      (CW)
  ) u_frame_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.parallelload),
    .inc_i   (bus.peripheralclkedge),
    .count_o (bus.bitcount),
    .wrap_o  (bus.framedone)
  );

endmodule
`default_nettype wire

// File: doc/edge_shift_register.md
Name: edge_shift_register

Overview:
- Shift register stage directly downstream of the input conditioner, clocked on the system clock.
- Consumes the conditioner's one-cycle edge strobe and its conditioned serial data.
- Builds WIDTH-bit words from serial input (SIPO) and, after a parallel load, emits a loaded word serially (PISO).
- Tracks bit position and flags frame completion; feeds the downstream FSM / address latch in the SPI-memory datapath.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1: shift left (serial in at bit 0, serial out from bit WIDTH-1); 0: shift right (serial in at bit WIDTH-1, serial out from bit 0).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- peripheralclkedge  input  1  one-cycle shift strobe from the conditioner's positiveedge output.
- serialdatain  input  1  bit sampled on a shift, from the conditioner's conditioned output.
- parallelload  input  1  one-cycle load strobe.
- paralleldatain  input  WIDTH  word captured on parallelload.
- paralleldataout  output  WIDTH  current register contents.
- serialdataout  output  1  current outgoing bit; combinational from the register.
- bitcount  output  $clog2(WIDTH+1)  bits shifted since the last load, reset or frame wrap.
- framedone  output  1  one-cycle pulse when a full word has been shifted.

Behaviour:
- Reset: rst_n low at a rising clk -> register, bitcount and framedone all 0. Reset overrides load and shift. Reset mid-frame discards the partial word.
- Priority per cycle: reset > parallelload > peripheralclkedge > hold.
- parallelload:
  - register <= paralleldatain, bitcount <= 0, framedone <= 0.
  - A shift strobe in the same cycle is dropped, not deferred.
- Shift (peripheralclkedge=1, parallelload=0):
  - MSB_FIRST=1: register <= {register[WIDTH-2:0], serialdatain}.
  - MSB_FIRST=0: register <= {serialdatain, register[WIDTH-1:1]}.
  - If bitcount==WIDTH-1: bitcount <= 0 and framedone <= 1. Otherwise bitcount <= bitcount+1 and framedone <= 0.
- Hold (no strobe): register and bitcount unchanged; framedone <= 0.
- framedone:
  - Registered; asserted exactly in the cycle after the completing shift, for one cycle.
  - Back-to-back frames give pulses every WIDTH strobes with no dead strobe.
- serialdataout:
  - Equals register[WIDTH-1] when MSB_FIRST=1, register[0] when MSB_FIRST=0.
  - Valid from the cycle after a load or shift, with no extra pipeline stage.
- Latency:
  - A load or shift is visible on paralleldataout one clk after the strobe cycle.
  - The first loaded bit appears on serialdataout one clk after parallelload.
- Strobes are assumed single-cycle (guaranteed upstream). A strobe held high N cycles shifts N times; no internal edge detection.
- bitcount never exceeds WIDTH-1.
- Combinational loops: none; all outputs except serialdataout come directly from flops.

Decomposition:
- Shared package: width of bitcount as a function of WIDTH; shift-direction encoding constants for MSB_FIRST.
- One sub-module is natural: frame_bit_counter, a mod-WIDTH counter with clear, increment and wrap-pulse output, reusable by the downstream FSM.
- The shift datapath stays in the top module.

Test Plan:
- Reset: load 8'hA5, then rst_n=0 for one cycle -> paralleldataout=0, bitcount=0, framedone=0, serialdataout=0.
- SIPO, MSB_FIRST=1: shift bits 1,0,1,1,0,0,1,0, with strobes spaced 3 clks apart -> paralleldataout=8'hB2, bitcount 1..7 then 0, one framedone pulse one clk after the 8th strobe.
- PISO: parallelload 8'hC3, then 8 strobes -> serialdataout sequence 1,1,0,0,0,0,1,1. With serialdatain=0, paralleldataout=8'h00 after the 8th shift.
- Simultaneous strobes: load 8'h3C in the same cycle as a shift strobe -> register=8'h3C, bitcount=0, no shift.
- Mid-frame reset: after 5 strobes, rst_n=0 -> bitcount=0. A new 8-strobe frame gives framedone only after strobe 8 of the new frame.
- MSB_FIRST=0: shift bits 1,0,0,0,0,0,0,0 -> paralleldataout=8'h01. Back-to-back 16 strobes -> two framedone pulses 8 strobes apart.
